// File: rtl/root_5_en_multi_cycle_struct.sv
// root_5_en_multi_cycle_struct
// Integer fifth root: res = floor(x^(1/5)) for an unsigned w-bit operand.
// Bitwise binary search from the MSB of the root down. Each candidate is
// raised to the fifth power by one shared multiplier, one multiply per edge.
// All registers advance only on edges where clk_en=1.
//
// Optional feature macro: ROOT_5_EXACT_EN
//   defined   : exact = (res^5 == x), updated together with res
//   undefined : exact is tied to 0
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clk_en   in   edge enable
//   x_vld    in   operand valid, sampled in IDLE only
//   x        in   unsigned operand [w-1:0]
//   busy     out  high while not in IDLE
//   res_vld  out  result valid, one enabled-cycle pulse
//   res      out  root [rw-1:0], held until the next result
//   exact    out  res^5 == x (only with ROOT_5_EXACT_EN)
//
// state | meaning
// IDLE  | waiting for x_vld, result registers hold
// TRY   | form candidate = root | (1 << idx), seed p with it
// MUL   | p <= p * cand, four times, leaving p = cand^5
// CMP   | keep candidate if p <= x_r; next bit or finish
module root_5_en_multi_cycle_struct #(
   parameter int w = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 x_vld,
   input  logic [w-1:0]         x,
   output logic                 busy,
   output logic                 res_vld,
   output logic [(w+4)/5-1:0]   res,
   output logic                 exact
);
   localparam int rw = (w + 4) / 5;
   localparam int PW = 5 * rw;
   localparam int IW = (rw > 1) ? $clog2(rw) : 1;

   typedef enum logic [1:0] {S_IDLE, S_TRY, S_MUL, S_CMP} state_t;

   state_t          state_q, state_d;
   logic [w-1:0]    x_r_q, x_r_d;
   logic [rw-1:0]   root_q, root_d;
   logic [rw-1:0]   cand_q, cand_d;
   logic [rw-1:0]   res_q, res_d;
   logic [PW-1:0]   p_q, p_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            res_vld_q, res_vld_d;

   logic [rw-1:0]   bit_sel;
   logic [PW-1:0]   x_ext;
   logic            p_le_x;

   assign bit_sel = rw'(1) << idx_q;
   assign x_ext   = PW'(x_r_q);
   // p holds the full cand^5 (PW bits), so the compare never sees truncation
   assign p_le_x  = (p_q <= x_ext);

`ifdef ROOT_5_EXACT_EN
   logic [PW-1:0]   root_pow_q, root_pow_d;
   logic            exact_q, exact_d;
`endif

   always_comb begin
      state_d   = state_q;
      x_r_d     = x_r_q;
      root_d    = root_q;
      cand_d    = cand_q;
      res_d     = res_q;
      p_d       = p_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      res_vld_d = 1'b0;
`ifdef ROOT_5_EXACT_EN
      root_pow_d = root_pow_q;
      exact_d    = exact_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (x_vld) begin
               x_r_d   = x;
               root_d  = '0;
               idx_d   = IW'(rw - 1);
               state_d = S_TRY;
`ifdef ROOT_5_EXACT_EN
               root_pow_d = '0;
`endif
            end
         end
         S_TRY: begin
            cand_d  = root_q | bit_sel;
            p_d     = PW'(root_q | bit_sel);
            cnt_d   = '0;
            state_d = S_MUL;
         end
         S_MUL: begin
            p_d   = p_q * PW'(cand_q);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = S_CMP;
         end
         S_CMP: begin
            if (p_le_x) begin
               root_d = cand_q;
`ifdef ROOT_5_EXACT_EN
               root_pow_d = p_q;
`endif
            end
            if (idx_q != '0) begin
               idx_d   = idx_q - IW'(1);
               state_d = S_TRY;
            end else begin
               res_d     = p_le_x ? cand_q : root_q;
               res_vld_d = 1'b1;
               state_d   = S_IDLE;
`ifdef ROOT_5_EXACT_EN
               // root_pow is still the previous accepted power this edge
               exact_d = p_le_x ? (p_q == x_ext) : (root_pow_q == x_ext);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_r_q     <= '0;
         root_q    <= '0;
         cand_q    <= '0;
         res_q     <= '0;
         p_q       <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         res_vld_q <= 1'b0;
      end else if (clk_en) begin
         state_q   <= state_d;
         x_r_q     <= x_r_d;
         root_q    <= root_d;
         cand_q    <= cand_d;
         res_q     <= res_d;
         p_q       <= p_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         res_vld_q <= res_vld_d;
      end
   end

`ifdef ROOT_5_EXACT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         root_pow_q <= '0;
         exact_q    <= 1'b0;
      end else if (clk_en) begin
         root_pow_q <= root_pow_d;
         exact_q    <= exact_d;
      end
   end
   assign exact = exact_q;
`else
   assign exact = 1'b0;
`endif

   assign busy    = (state_q != S_IDLE);
   assign res_vld = res_vld_q;
   assign res     = res_q;

endmodule

// File: tb/tb_root_5_en_multi_cycle_struct.sv
module tb_root_5_en_multi_cycle_struct;
   localparam int W  = 8;
   localparam int RW = (W + 4) / 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clk_en = 1'b1;
   logic          x_vld = 1'b0;
   logic [W-1:0]  x = '0;
   logic          busy;
   logic          res_vld;
   logic [RW-1:0] res;
   logic          exact;

   int checks = 0;
   int failures = 0;
   int exp_res_q[$];
   int exp_ex_q[$];

   root_5_en_multi_cycle_struct #(.w(W)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .x_vld(x_vld), .x(x),
      .busy(busy), .res_vld(res_vld), .res(res), .exact(exact)
   );

   always #5 clk = ~clk;

   function automatic int pow5(input int n);
      return n * n * n * n * n;
   endfunction

   function automatic int root5(input int xv);
      int r = 0;
      while (pow5(r + 1) <= xv) r++;
      return r;
   endfunction

   function automatic int exact_model(input int xv);
`ifdef ROOT_5_EXACT_EN
      return (pow5(root5(xv)) == xv) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int xv);
      exp_res_q.push_back(root5(xv));
      exp_ex_q.push_back(exact_model(xv));
   endtask

   // Drive one operand so it is accepted on the next posedge (E0).
   task automatic send(input int xv, input bit push, input bit hold);
      @(negedge clk);
      x = W'(xv);
      x_vld = 1'b1;
      clk_en = 1'b1;
      if (push) push_exp(xv);
      @(posedge clk);
      #1;
      if (!hold) x_vld = 1'b0;
   endtask

   // Counts enabled edges until res_vld, then checks against the scoreboard.
   task automatic wait_res(input string tag, input int exp_lat, input bit gated);
      int edges = 0;
      int cyc = 1;
      bit got = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         clk_en = gated ? ((cyc % 3) == 0) : 1'b1;
         cyc++;
         @(posedge clk);
         if (clk_en) edges++;
         #1;
         if (res_vld === 1'b1) begin
            got = 1;
            break;
         end
      end
      chk({tag, "_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, "_lat"}, edges, exp_lat);
         chk({tag, "_sb_nonempty"}, 32'(exp_res_q.size() > 0), 32'd1);
         if (exp_res_q.size() > 0) begin
            chk({tag, "_res"}, 32'(res), exp_res_q.pop_front());
            chk({tag, "_exact"}, 32'(exact), exp_ex_q.pop_front());
         end
      end
   endtask

   initial begin
      bit seen;
      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_res_vld", 32'(res_vld), 0);
      chk("rst_res", 32'(res), 0);
      chk("rst_exact", 32'(exact), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // basic perfect power, latency 12
      send(243, 1, 0);
      chk("basic_busy", 32'(busy), 1);
      wait_res("basic_243", 12, 0);
      @(posedge clk); #1;
      chk("basic_pulse_clear", 32'(res_vld), 0);
      chk("basic_res_hold", 32'(res), 3);

      // boundaries
      send(242, 1, 0); wait_res("b_242", 12, 0);
      send(32, 1, 0);  wait_res("b_32", 12, 0);
      send(31, 1, 0);  wait_res("b_31", 12, 0);
      send(0, 1, 0);   wait_res("b_0", 12, 0);
      send(255, 1, 0); wait_res("b_255", 12, 0);

      // back-to-back with x_vld held; x wiggles while busy
      send(1, 1, 1);
      x = 8'd255;
      @(posedge clk); #1;
      x = 8'd100;
      push_exp(100);
      @(posedge clk); #1;
      wait_res("b2b_1", 10, 0);
      @(posedge clk); #1;
      x_vld = 1'b0;
      chk("b2b_accept_busy", 32'(busy), 1);
      chk("b2b_pulse_clear", 32'(res_vld), 0);
      wait_res("b2b_2", 12, 0);

      // clk_en 1-of-3
      send(250, 1, 0);
      wait_res("gated_250", 12, 1);
      @(negedge clk); clk_en = 1'b0;
      @(posedge clk); #1;
      chk("gated_hold1", 32'(res_vld), 1);
      @(negedge clk); clk_en = 1'b0;
      @(posedge clk); #1;
      chk("gated_hold2", 32'(res_vld), 1);
      @(negedge clk); clk_en = 1'b1;
      @(posedge clk); #1;
      chk("gated_clear", 32'(res_vld), 0);

      // pow_5 outputs fed back
      for (int n = 0; n <= 3; n++) begin
         send(pow5(n), 1, 0);
         wait_res($sformatf("pow_fb_%0d", n), 12, 0);
      end

      // full sweep
      for (int v = 0; v < 256; v++) begin
         send(v, 1, 0);
         wait_res($sformatf("sweep_%0d", v), 12, 0);
      end

      // reset mid-MUL aborts with no later pulse
      send(200, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_res_vld", 32'(res_vld), 0);
      chk("abort_res", 32'(res), 0);
      chk("abort_exact", 32'(exact), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (res_vld !== 1'b0) seen = 1;
      end
      chk("abort_no_pulse", 32'(seen), 0);
      chk("abort_idle", 32'(busy), 0);
      chk("sb_drained", exp_res_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
